// File: rtl/tick_gen_multi_if.sv
// tick_gen_multi_if: divisor-write bus carrying per-channel divisor updates into tick_gen_multi.
interface tick_gen_multi_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32,
  localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
  logic             div_wr;
  logic [SEL_W-1:0] div_sel;
  logic [CNT_W-1:0] div_val;
  modport master (output div_wr, div_sel, div_val);
  modport slave  (input  div_wr, div_sel, div_val);
endinterface

// File: rtl/tick_gen_multi.sv
// tick_gen_multi: NUM_CH programmable tick dividers with pause, single-step, phase-align and divisor bus.
// Optional blink square wave on channel 0 enabled by macro TICK_GEN_BLINK_EN.
module tick_gen_multi #(
  parameter int CLK_FRQ = 50_000_000,
  parameter int NUM_CH  = 4,
  parameter int CNT_W   = 32,
  localparam int SEL_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              manual_set,
  input  logic              manual_step,
  input  logic              sync_clr,
  tick_gen_multi_if.slave   bus,
  output logic [NUM_CH-1:0] tick,
  output logic              blink
);
  logic [CNT_W-1:0]  cnt_q [NUM_CH];
  logic [CNT_W-1:0]  cnt_d [NUM_CH];
  logic [CNT_W-1:0]  div_q [NUM_CH];
  logic [CNT_W-1:0]  div_d [NUM_CH];
  logic [NUM_CH-1:0] tick_q, tick_d;
  logic              step_q, step_d, step_rise;
  always_comb begin
    step_d    = manual_step;
    step_rise = manual_set & manual_step & ~step_q;
    tick_d    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      logic             wr;
      logic [CNT_W-1:0] term;
      wr       = bus.div_wr && (bus.div_sel == SEL_W'(i));
      term     = (div_q[i] == '0) ? '0 : div_q[i] - 1'b1;
      div_d[i] = wr ? bus.div_val : div_q[i];
      cnt_d[i] = cnt_q[i];
      // sync_clr and a divisor write both restart the period; a pause only lets step pulses through
      if (sync_clr || wr) cnt_d[i] = '0;
      else if (manual_set) tick_d[i] = step_rise;
      else if (cnt_q[i] == term) begin
        cnt_d[i]  = '0;
        tick_d[i] = 1'b1;
      end else cnt_d[i] = cnt_q[i] + 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_q <= '0;
      step_q <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= '0;
        div_q[i] <= CNT_W'(CLK_FRQ);
      end
    end else begin
      tick_q <= tick_d;
      step_q <= step_d;
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= cnt_d[i];
        div_q[i] <= div_d[i];
      end
    end
  end
  assign tick = tick_q;
`ifdef TICK_GEN_BLINK_EN
  logic blink_q, blink_d;
  assign blink_d = sync_clr ? 1'b0 : blink_q ^ tick_q[0];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) blink_q <= 1'b0;
    else blink_q <= blink_d;
  end
  assign blink = blink_q;
`else
  assign blink = 1'b0;
`endif
endmodule

// File: tb/tb_tick_gen_multi.sv
// tb_tick_gen_multi: directed checks of tick_gen_multi with CLK_FRQ=10, NUM_CH=4, CNT_W=8.
module tb_tick_gen_multi;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       manual_set = 1'b0;
  logic       manual_step = 1'b0;
  logic       sync_clr = 1'b0;
  logic [3:0] tick;
  logic       blink;
  logic [3:0] et;
  logic       eb = 1'b0;
  logic       le0 = 1'b0;
  int         checks = 0;
  int         errors = 0;
  tick_gen_multi_if #(.NUM_CH(4), .CNT_W(8)) bus ();
  tick_gen_multi #(.CLK_FRQ(10), .NUM_CH(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .manual_set(manual_set), .manual_step(manual_step),
    .sync_clr(sync_clr), .bus(bus), .tick(tick), .blink(blink)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step_chk(input string tag, input int k, input logic [3:0] exp_t);
    logic sc;
    sc = sync_clr;
    @(posedge clk);
    #1;
    eb  = sc ? 1'b0 : eb ^ le0;
    le0 = exp_t[0];
    check($sformatf("%s tick k=%0d", tag, k), 32'(tick), 32'(exp_t));
`ifdef TICK_GEN_BLINK_EN
    check($sformatf("%s blink k=%0d", tag, k), 32'(blink), 32'(eb));
`else
    check($sformatf("%s blink k=%0d", tag, k), 32'(blink), 32'(1'b0));
`endif
  endtask
  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    manual_set = 1'b0;
    manual_step = 1'b0;
    sync_clr = 1'b0;
    bus.div_wr = 1'b0;
    bus.div_sel = '0;
    bus.div_val = '0;
    repeat (2) @(posedge clk);
    #1;
    check({tag, " rst tick"}, 32'(tick), 32'(0));
    check({tag, " rst blink"}, 32'(blink), 32'(0));
    rst_n = 1'b1;
    eb = 1'b0;
    le0 = 1'b0;
  endtask
  initial begin
    do_reset("free");
    for (int k = 1; k <= 40; k++) begin
      et = (k % 10 == 0) ? 4'hF : 4'h0;
      step_chk("free", k, et);
    end
    rst_n = 1'b0;
    #1;
    check("async rst tick", 32'(tick), 32'(0));
    check("async rst blink", 32'(blink), 32'(0));
    do_reset("divwr");
    for (int k = 1; k <= 21; k++) begin
      bus.div_wr = (k == 5);
      bus.div_sel = 2'd2;
      bus.div_val = 8'd3;
      et = (k % 10 == 0) ? 4'b1011 : 4'b0000;
      if (k >= 8 && (k - 8) % 3 == 0) et[2] = 1'b1;
      step_chk("divwr", k, et);
    end
    do_reset("manual");
    for (int k = 1; k <= 31; k++) begin
      manual_set = (k >= 4 && k <= 23);
      manual_step = (k >= 8 && k <= 10) || (k >= 15 && k <= 17) || (k == 26);
      et = (k == 8 || k == 15 || k == 30) ? 4'hF : 4'h0;
      step_chk("manual", k, et);
    end
    do_reset("sync");
    for (int k = 1; k <= 24; k++) begin
      bus.div_wr = (k == 1) || (k == 13);
      bus.div_sel = (k == 1) ? 2'd1 : 2'd3;
      bus.div_val = (k == 1) ? 8'd0 : 8'd2;
      sync_clr = (k == 13);
      et = '0;
      et[0] = (k == 10 || k == 23);
      et[2] = et[0];
      et[1] = (k >= 2 && k != 13);
      et[3] = (k == 10) || (k >= 15 && (k - 15) % 2 == 0);
      step_chk("sync", k, et);
    end
    sync_clr = 1'b0;
    bus.div_wr = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
